// File: rtl/xc_malu_pkg.sv
// Shared definitions for the multi-cycle multiply ALU sequencer: state
// encoding, operation/width indices and per-width iteration targets.
package xc_malu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } malu_state_t;

  localparam int NumOps   = 6;
  localparam int OpMul    = 0;
  localparam int OpMulh   = 1;
  localparam int OpMulhu  = 2;
  localparam int OpMulhsu = 3;
  localparam int OpClmul  = 4;
  localparam int OpClmulh = 5;

  localparam int NumPw   = 5;
  localparam int PwIdx32 = 0;
  localparam int PwIdx16 = 1;
  localparam int PwIdx8  = 2;
  localparam int PwIdx4  = 3;
  localparam int PwIdx2  = 4;

  localparam int CountW = 6;
  localparam logic [CountW-1:0] TgtPw32 = 6'd32;
  localparam logic [CountW-1:0] TgtPw16 = 6'd16;
  localparam logic [CountW-1:0] TgtPw8  = 6'd8;
  localparam logic [CountW-1:0] TgtPw4  = 6'd4;
  localparam logic [CountW-1:0] TgtPw2  = 6'd2;

  // Only full-width high-half operations return the upper accumulator word.
  function automatic logic isHighHalf(input logic [NumOps-1:0] op,
                                      input logic [NumPw-1:0]  pw);
    return pw[PwIdx32] & (op[OpMulh] | op[OpMulhu] | op[OpMulhsu] | op[OpClmulh]);
  endfunction

endpackage

// File: rtl/xc_malu_seq_fsm.sv
// State and iteration-count register for the multiply sequencer; emits
// one-cycle accept/step/capture strobes for the datapath registers.
module xc_malu_seq_fsm
  import xc_malu_pkg::*;
(
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic              i_step_ready,
  output malu_state_t       o_state,
  output logic [CountW-1:0] o_count,
  output logic              o_accept,
  output logic              o_step,
  output logic              o_capture
);

  malu_state_t       r_state;
  malu_state_t       w_next;
  logic [CountW-1:0] r_count;
  logic              w_last;

  // A datapath that never signals completion is cut off at the full-width count.
  assign w_last = i_step_ready || (r_count == TgtPw32);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= StIdle;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (o_accept) begin
        r_count <= '0;
      end else if (o_step) begin
        r_count <= r_count + CountW'(1);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    o_accept  = 1'b0;
    o_step    = 1'b0;
    o_capture = 1'b0;
    if (i_flush) begin
      w_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_valid) begin
            o_accept = 1'b1;
            w_next   = StRun;
          end
        end
        StRun: begin
          if (w_last) begin
            o_capture = 1'b1;
            w_next    = StDone;
          end else begin
            o_step = 1'b1;
          end
        end
        StDone:  w_next = StIdle;
        default: w_next = StIdle;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_count = r_count;

endmodule

// File: rtl/xc_malu_seq.sv
// Multi-cycle multiply ALU sequencer: accepts a request, iterates the sibling
// step datapath until it reports completion, then returns one product half.
module xc_malu_seq
  import xc_malu_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        op_mul,
  input  logic        op_mulh,
  input  logic        op_mulhu,
  input  logic        op_mulhsu,
  input  logic        op_clmul,
  input  logic        op_clmulh,
  input  logic        pw_32,
  input  logic        pw_16,
  input  logic        pw_8,
  input  logic        pw_4,
  input  logic        pw_2,
  input  logic [63:0] step_n_acc,
  input  logic [31:0] step_n_arg_0,
  input  logic        step_ready,
  output logic [5:0]  step_count,
  output logic [63:0] step_acc,
  output logic [31:0] step_arg_0,
  output logic        carryless,
  output logic        lhs_sign,
  output logic        rhs_sign,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result
);

  malu_state_t       w_state;
  logic [CountW-1:0] w_count;
  logic              w_accept;
  logic              w_step;
  logic              w_capture;
  logic              w_active;
  logic              w_unused;
  logic [63:0]       r_acc;
  logic [31:0]       r_arg_0;
  logic [31:0]       r_result;
  logic [NumOps-1:0] r_op;
  logic [NumPw-1:0]  r_pw;

  xc_malu_seq_fsm u_fsm (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .i_valid      (valid),
    .i_flush      (flush),
    .i_step_ready (step_ready),
    .o_state      (w_state),
    .o_count      (w_count),
    .o_accept     (w_accept),
    .o_step       (w_step),
    .o_capture    (w_capture)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_acc    <= '0;
      r_arg_0  <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_pw     <= '0;
    end else begin
      if (w_accept) begin
        r_acc   <= '0;
        r_arg_0 <= rs2;
        r_op    <= {op_clmulh, op_clmul, op_mulhsu, op_mulhu, op_mulh, op_mul};
        r_pw    <= {pw_2, pw_4, pw_8, pw_16, pw_32};
      end else if (w_step) begin
        r_acc   <= step_n_acc;
        r_arg_0 <= step_n_arg_0;
      end
      if (w_capture) begin
        r_result <= isHighHalf(r_op, r_pw) ? r_acc[63:32] : r_acc[31:0];
      end
    end
  end

  assign w_active   = (w_state != StIdle);
  assign busy       = w_active;
  assign ready      = (w_state == StDone) && !flush;
  assign carryless  = w_active & (r_op[OpClmul] | r_op[OpClmulh]);
  assign lhs_sign   = w_active & (r_op[OpMulh] | r_op[OpMulhsu]);
  assign rhs_sign   = w_active & r_op[OpMulh];
  assign step_count = w_count;
  assign step_acc   = r_acc;
  assign step_arg_0 = r_arg_0;
  assign result     = r_result;

  // rs1 feeds the datapath directly from the requester; narrow widths only matter to the datapath.
  assign w_unused = ^{rs1, r_pw, r_op};

endmodule

// File: tb/tb_xc_malu_seq.sv
// Self-checking bench for xc_malu_seq with a behavioural step datapath and a
// scoreboard fed from plain-arithmetic product expectations.
module tb_xc_malu_seq;

  typedef struct {
    logic [31:0] res;
    bit          checkRes;
    int          stamp;
    int          lat;
    string       name;
  } exp_t;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        valid;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [5:0]  opSel;
  logic [4:0]  pwSel;
  logic [63:0] step_n_acc;
  logic [31:0] step_n_arg_0;
  logic        step_ready;
  logic [5:0]  step_count;
  logic [63:0] step_acc;
  logic [31:0] step_arg_0;
  logic        carryless;
  logic        lhs_sign;
  logic        rhs_sign;
  logic        busy;
  logic        ready;
  logic [31:0] result;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cyc         = 0;
  int          curOp       = 0;
  logic [31:0] lastRes     = '0;
  exp_t        sbq[$];
  exp_t        monE;
  int          dpTarget;
  logic [63:0] dpLhs;
  logic [63:0] dpAddend;

  xc_malu_seq dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .valid        (valid),
    .flush        (flush),
    .rs1          (rs1),
    .rs2          (rs2),
    .op_mul       (opSel[0]),
    .op_mulh      (opSel[1]),
    .op_mulhu     (opSel[2]),
    .op_mulhsu    (opSel[3]),
    .op_clmul     (opSel[4]),
    .op_clmulh    (opSel[5]),
    .pw_32        (pwSel[0]),
    .pw_16        (pwSel[1]),
    .pw_8         (pwSel[2]),
    .pw_4         (pwSel[3]),
    .pw_2         (pwSel[4]),
    .step_n_acc   (step_n_acc),
    .step_n_arg_0 (step_n_arg_0),
    .step_ready   (step_ready),
    .step_count   (step_count),
    .step_acc     (step_acc),
    .step_arg_0   (step_arg_0),
    .carryless    (carryless),
    .lhs_sign     (lhs_sign),
    .rhs_sign     (rhs_sign),
    .busy         (busy),
    .ready        (ready),
    .result       (result)
  );

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) cyc <= cyc + 1;

  // Stand-in for the sibling step datapath: one shift-add (or xor) per count.
  always_comb begin
    dpTarget     = 63;
    dpLhs        = '0;
    dpAddend     = '0;
    step_n_acc   = step_acc;
    step_n_arg_0 = step_arg_0 >> 1;
    case (pwSel)
      5'b00001: dpTarget = 32;
      5'b00010: dpTarget = 16;
      5'b00100: dpTarget = 8;
      5'b01000: dpTarget = 4;
      5'b10000: dpTarget = 2;
      default:  dpTarget = 63;
    endcase
    step_ready = (int'(step_count) == dpTarget);
    dpLhs      = lhs_sign ? {{32{rs1[31]}}, rs1} : {32'b0, rs1};
    dpAddend   = dpLhs << step_count;
    if (step_arg_0[0]) begin
      if (carryless) step_n_acc = step_acc ^ dpAddend;
      else if (rhs_sign && step_count == 6'd31) step_n_acc = step_acc - dpAddend;
      else step_n_acc = step_acc + dpAddend;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int pwTarget(input logic [4:0] pw);
    case (pw)
      5'b00001: return 32;
      5'b00010: return 16;
      5'b00100: return 8;
      5'b01000: return 4;
      5'b10000: return 2;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ ({32'b0, a} << i);
    return r;
  endfunction

  // Expected result straight from the arithmetic definition of each operation.
  function automatic logic [31:0] refResult(input int op, input int tgt,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] sa, sb, ua, ub;
    logic [31:0] bm;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (tgt != 32) begin
      bm = b & ((32'h1 << tgt) - 32'h1);
      p  = (op >= 4) ? clmul64(a, bm) : ua * {32'b0, bm};
      return p[31:0];
    end
    case (op)
      1:       p = sa * sb;
      2:       p = ua * ub;
      3:       p = sa * ub;
      4, 5:    p = clmul64(a, b);
      default: p = ua * ub;
    endcase
    return (op == 0 || op == 4) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [2:0] refModes(input int op);
    case (op)
      1:       return 3'b011;
      3:       return 3'b010;
      4, 5:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge g_clk) begin
    if (g_resetn && ready) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected ready", 64'(ready), 64'd0);
      end else begin
        monE = sbq.pop_front();
        checkOutput({monE.name, " latency"}, 64'(cyc - monE.stamp), 64'(monE.lat));
        if (monE.checkRes) checkOutput({monE.name, " result"}, 64'(result), 64'(monE.res));
      end
    end
  end

  always @(negedge g_clk) begin
    if (g_resetn) begin
      checkOutput("modes", {61'b0, carryless, lhs_sign, rhs_sign},
                  {61'b0, (busy ? refModes(curOp) : 3'b000)});
    end
  end

  task automatic setInputs(input int op, input logic [4:0] pw,
                           input logic [31:0] a, input logic [31:0] b);
    opSel = 6'(1 << op);
    pwSel = pw;
    rs1   = a;
    rs2   = b;
    curOp = op;
    valid = 1'b1;
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic applyStimulus(input int op, input logic [4:0] pw, input logic [31:0] a,
                               input logic [31:0] b, input bit keepValid, input string name);
    exp_t e;
    int   tgt;
    int   n;
    setInputs(op, pw, a, b);
    tgt     = pwTarget(pw);
    e.stamp = cyc;
    e.name  = name;
    if (tgt == 0) begin
      e.checkRes = 1'b0;
      e.lat      = 34;
      e.res      = '0;
    end else begin
      e.checkRes = 1'b1;
      e.lat      = tgt + 2;
      e.res      = refResult(op, tgt, a, b);
      lastRes    = e.res;
    end
    sbq.push_back(e);
    @(negedge g_clk);
    checkOutput({name, " busy"}, 64'(busy), 64'd1);
    n = 1;
    while (!ready && n < 60) begin
      @(negedge g_clk);
      n++;
    end
    if (!ready) checkOutput({name, " ready timeout"}, 64'(ready), 64'd1);
    @(negedge g_clk);
    if (!keepValid) begin
      valid = 1'b0;
      @(negedge g_clk);
    end
  endtask

  task automatic waitForCount(input int target, input string name);
    int n;
    n = 0;
    while (!(busy && int'(step_count) == target) && n < 60) begin
      @(negedge g_clk);
      n++;
    end
    checkOutput({name, " reached count"}, {57'b0, busy, step_count}, {57'b0, 1'b1, 6'(target)});
  endtask

  task automatic applyFlush(input int op, input logic [31:0] a, input logic [31:0] b,
                            input int atCount);
    setInputs(op, 5'b00001, a, b);
    waitForCount(atCount, "flush");
    flush = 1'b1;
    valid = 1'b0;
    @(negedge g_clk);
    checkOutput("flush busy", 64'(busy), 64'd0);
    checkOutput("flush result held", 64'(result), 64'(lastRes));
    flush = 1'b0;
    @(negedge g_clk);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, " flags+count"},
                {53'b0, busy, ready, carryless, lhs_sign, rhs_sign, step_count}, 64'd0);
    checkOutput({name, " acc"}, step_acc, 64'd0);
    checkOutput({name, " arg_0"}, 64'(step_arg_0), 64'd0);
    checkOutput({name, " result"}, 64'(result), 64'd0);
  endtask

  task automatic applyMidReset(input int op, input logic [31:0] a, input logic [31:0] b,
                               input int atCount);
    setInputs(op, 5'b00001, a, b);
    waitForCount(atCount, "reset");
    #2 g_resetn = 1'b0;
    #1 checkResetOutputs("mid-op reset");
    valid   = 1'b0;
    lastRes = '0;
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  initial begin
    int op;
    int r;
    logic [4:0] pw;
    valid    = 1'b0;
    flush    = 1'b0;
    opSel    = '0;
    pwSel    = 5'b00001;
    rs1      = '0;
    rs2      = '0;
    g_resetn = 1'b1;
    #1 g_resetn = 1'b0;
    repeat (2) @(negedge g_clk);
    checkResetOutputs("power-on reset");
    g_resetn = 1'b1;

    applyStimulus(0, 5'b00001, 32'd7, 32'd6, 1'b0, "mul 7x6");
    applyStimulus(2, 5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu max");
    applyStimulus(1, 5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulh -1x-1");
    applyStimulus(4, 5'b00001, 32'd3, 32'd3, 1'b0, "clmul 3x3");

    applyFlush(0, 32'd12345, 32'd6789, 10);
    applyStimulus(3, 5'b00001, 32'h8000_0001, 32'h1234_5678, 1'b0, "post-flush mulhsu");

    applyMidReset(5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 20);
    applyStimulus(2, 5'b00001, 32'h0001_0000, 32'h0001_0000, 1'b0, "post-reset mulhu");

    applyStimulus(0, 5'b00001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "b2b first");
    applyStimulus(5, 5'b00001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, "b2b second");

    applyStimulus(0, 5'b00010, 32'hFFFF_FFFF, 32'h0003_8001, 1'b0, "mul pw16");
    applyStimulus(4, 5'b10000, 32'h0000_0007, 32'h0000_0003, 1'b0, "clmul pw2");
    applyStimulus(0, 5'b00011, 32'h5555_5555, 32'h3333_3333, 1'b0, "bad pw");
    applyStimulus(1, 5'b00000, 32'h5555_5555, 32'h3333_3333, 1'b0, "no pw");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      r  = $urandom_range(0, 7);
      pw = (r < 3) ? 5'b00001 : 5'(1 << (r - 3));
      applyStimulus(op, pw, randOperand(), randOperand(), ($urandom_range(0, 3) == 0),
                    "random");
    end
    valid = 1'b0;

    repeat (4) @(negedge g_clk);
    checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/xc_malu_seq.md
XC_MALU_SEQ -- requirements
Module: xc_malu_seq

Interface
REQ-001 The block SHALL have one clock, g_clk, and an asynchronous active-low reset, g_resetn.
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
- g_clk  in  1  clock
- g_resetn  in  1  async active-low reset
- valid  in  1  operation request, held high until ready
- flush  in  1  abort current operation
- rs1, rs2  in  32  operands
- op_mul, op_mulh, op_mulhu, op_mulhsu, op_clmul, op_clmulh  in  1 each  one-hot operation select
- pw_32, pw_16, pw_8, pw_4, pw_2  in  1 each  packed width, one-hot
- step_n_acc  in  64  next accumulator from step datapath
- step_n_arg_0  in  32  next shifted multiplier from step datapath
- step_ready  in  1  step datapath iteration-complete flag
- step_count  out  6  iteration counter to datapath
- step_acc  out  64  accumulator to datapath
- step_arg_0  out  32  multiplier shift register to datapath
- carryless, lhs_sign, rhs_sign  out  1 each  datapath mode
- busy  out  1  operation in progress
- ready  out  1  result valid, one-cycle pulse
- result  out  32  selected product half

Function
REQ-003 States SHALL be IDLE, RUN, DONE.
REQ-004 In IDLE with valid=1 and flush=0, the block SHALL load acc=0, arg_0=rs2, count=0, latch op and pw, and enter RUN.
REQ-005 In RUN with step_ready=0, each cycle SHALL load acc<=step_n_acc, arg_0<=step_n_arg_0, count<=count+1.
REQ-006 In RUN with step_ready=1, the block SHALL hold acc and capture result, then enter DONE.
- Result is acc[63:32] for mulh, mulhu, mulhsu and clmulh.
- Result is acc[31:0] for mul and clmul, and for every pw other than pw_32.
REQ-007 DONE SHALL assert ready for exactly one cycle, then return to IDLE unconditionally.
REQ-008 The requester SHALL drop valid in the cycle after ready; valid still high in IDLE starts a new operation.
REQ-009 Latency for pw_32 SHALL be 34 cycles: accept in cycle 0, count 0..32 in cycles 1..33, ready in cycle 34.
REQ-010 Latency for narrower widths SHALL scale with the datapath target count of 16, 8, 4 or 2.
REQ-011 Mode outputs SHALL be decoded from the latched op:
- carryless=1 for clmul and clmulh.
- lhs_sign=1 for mulh and mulhsu.
- rhs_sign=1 for mulh only.
- All three are 0 in IDLE.
REQ-012 flush SHALL have priority over all other transitions: any state goes to IDLE next cycle, ready is not asserted, and result is unchanged.
REQ-013 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-014 Inputs rs1, rs2, op and pw SHALL be sampled only at accept; changes during RUN SHALL be ignored, except that rs1 is passed combinationally by the requester to the datapath.
REQ-015 A non-one-hot op or pw SHALL produce an undefined result but SHALL still return to IDLE within 34 cycles; count SHALL never exceed 32.

Reset
REQ-016 On g_resetn=0, asynchronously and at any point including mid-operation:
- The state SHALL be IDLE.
- count, acc, arg_0 and result SHALL be 0.
- ready, busy, carryless, lhs_sign and rhs_sign SHALL be 0.
REQ-017 After reset, the first valid SHALL be accepted in the first cycle that g_resetn=1.

Structure
REQ-018 State encoding, op-index constants and the per-width target counts (32/16/8/4/2) SHALL live in shared package xc_malu_pkg.
REQ-019 No internal sub-module is required; the step datapath (xc_malu_mul) SHALL remain a sibling instance wired through the step_* ports.
REQ-020 An optional FSM sub-module, xc_malu_seq_fsm, MAY hold state and count only.

Verification
REQ-021 mul, rs1=7, rs2=6, pw_32 -> ready in cycle 34, result=0x0000002A.
REQ-022 mulhu, rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE; mulh with the same operands -> result=0x00000000.
REQ-023 clmul, rs1=3, rs2=3 -> result=0x00000005, carryless=1 throughout RUN.
REQ-024 flush at count=10 -> IDLE next cycle, no ready pulse; a following valid completes correctly.
REQ-025 g_resetn low at count=20 -> all outputs 0 immediately; after release, mul 0x10000*0x10000 with mulhu -> result=0x00000001.
REQ-026 Back-to-back operations with valid held one extra cycle -> the second operation starts from IDLE, and both results are correct.
